// File: rtl/operand_stage.sv
// Operand fetch stage: reads the register file, tracks in-flight destinations in a
// scoreboard, bypasses same-cycle writeback data and hands a registered operand bundle downstream.
module operand_stage #(
    parameter bit embedded = 1'b1,
    localparam int unsigned RADDR_W = embedded ? 4 : 5,
    localparam int unsigned NREG    = 1 << RADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               InValid,
    output logic               InReady,
    input  logic [RADDR_W-1:0] InRs1Addr,
    input  logic [RADDR_W-1:0] InRs2Addr,
    input  logic [RADDR_W-1:0] InRdAddr,

    output logic [RADDR_W-1:0] Rs1Addr,
    output logic [RADDR_W-1:0] Rs2Addr,
    input  logic [31:0]        Rs1Data,
    input  logic [31:0]        Rs2Data,
    output logic [RADDR_W-1:0] RdAddr,
    output logic [31:0]        RdData,

    input  logic               WbValid,
    input  logic [RADDR_W-1:0] WbAddr,
    input  logic [31:0]        WbData,

    output logic               OutValid,
    input  logic               OutReady,
    output logic [31:0]        OutRs1Data,
    output logic [31:0]        OutRs2Data,
    output logic [RADDR_W-1:0] OutRdAddr
);

    logic [NREG-1:0]    pending_q,  pending_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_rs1_q,  out_rs1_d;
    logic [31:0]        out_rs2_q,  out_rs2_d;
    logic [RADDR_W-1:0] out_rd_q,   out_rd_d;

    logic               rs1_hz, rs2_hz, rd_hz;
    logic               in_ready, issue, wb_hit;
    logic [31:0]        rs1_op, rs2_op;

    // Register file ports are pass-through; writeback owns the write port every cycle.
    assign Rs1Addr = InRs1Addr;
    assign Rs2Addr = InRs2Addr;
    assign RdAddr  = WbValid ? WbAddr : '0;
    assign RdData  = WbData;

    // Hazard detection, issue decision and operand bypass.
    always_comb begin
        rs1_hz = (InRs1Addr != '0) && pending_q[InRs1Addr] && !(WbValid && (WbAddr == InRs1Addr));
        rs2_hz = (InRs2Addr != '0) && pending_q[InRs2Addr] && !(WbValid && (WbAddr == InRs2Addr));
        rd_hz  = (InRdAddr  != '0) && pending_q[InRdAddr]  && !(WbValid && (WbAddr == InRdAddr));

        in_ready = (!out_valid_q || OutReady) && !rs1_hz && !rs2_hz && !rd_hz;
        issue    = InValid && in_ready;
        wb_hit   = WbValid && (WbAddr != '0);

        rs1_op = '0;
        if (InRs1Addr != '0) begin
            rs1_op = (WbValid && (WbAddr == InRs1Addr)) ? WbData : Rs1Data;
        end
        rs2_op = '0;
        if (InRs2Addr != '0) begin
            rs2_op = (WbValid && (WbAddr == InRs2Addr)) ? WbData : Rs2Data;
        end
    end

    assign InReady = in_ready;

    // Next-state for scoreboard and output bundle; an issue's set overrides a same-register clear.
    always_comb begin
        pending_d   = pending_q;
        out_valid_d = out_valid_q && !OutReady;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        out_rd_d    = out_rd_q;

        if (wb_hit) begin
            pending_d[WbAddr] = 1'b0;
        end
        if (issue) begin
            if (InRdAddr != '0) begin
                pending_d[InRdAddr] = 1'b1;
            end
            out_valid_d = 1'b1;
            out_rs1_d   = rs1_op;
            out_rs2_d   = rs2_op;
            out_rd_d    = InRdAddr;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_rd_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_rs1_q   <= out_rs1_d;
            out_rs2_q   <= out_rs2_d;
            out_rd_q    <= out_rd_d;
        end
    end

    assign OutValid   = out_valid_q;
    assign OutRs1Data = out_rs1_q;
    assign OutRs2Data = out_rs2_q;
    assign OutRdAddr  = out_rd_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage (RV32E): hazards, bypass, backpressure, x0 and reset.
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InValid;
    logic        InReady;
    logic [3:0]  InRs1Addr, InRs2Addr, InRdAddr;
    logic [3:0]  Rs1Addr, Rs2Addr, RdAddr;
    logic [31:0] Rs1Data, Rs2Data, RdData;
    logic        WbValid;
    logic [3:0]  WbAddr;
    logic [31:0] WbData;
    logic        OutValid, OutReady;
    logic [31:0] OutRs1Data, OutRs2Data;
    logic [3:0]  OutRdAddr;

    logic [31:0] regs [16];
    logic        rf_load;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    operand_stage #(.embedded(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .InValid(InValid), .InReady(InReady),
        .InRs1Addr(InRs1Addr), .InRs2Addr(InRs2Addr), .InRdAddr(InRdAddr),
        .Rs1Addr(Rs1Addr), .Rs2Addr(Rs2Addr), .Rs1Data(Rs1Data), .Rs2Data(Rs2Data),
        .RdAddr(RdAddr), .RdData(RdData),
        .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutRs1Data(OutRs1Data), .OutRs2Data(OutRs2Data), .OutRdAddr(OutRdAddr)
    );

    // Register file model: x1..x15 preset to i*0x100 except x5=0x11, x0 reads zero.
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 16; i++) regs[i] <= (i == 5) ? 32'h11 : 32'(i) * 32'h100;
        end else if (RdAddr != 4'd0) begin
            regs[RdAddr] <= RdData;
        end
    end
    assign Rs1Data = (Rs1Addr == 4'd0) ? 32'd0 : regs[Rs1Addr];
    assign Rs2Data = (Rs2Addr == 4'd0) ? 32'd0 : regs[Rs2Addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd);
        InValid = v; InRs1Addr = rs1; InRs2Addr = rs2; InRdAddr = rd;
        #1;
    endtask

    task automatic wb(input logic v, input logic [3:0] a, input logic [31:0] d);
        WbValid = v; WbAddr = a; WbData = d;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rf_load = 1'b1; OutReady = 1'b0;
        instr(1'b0, 4'd0, 4'd0, 4'd0);
        wb(1'b0, 4'd0, 32'd0);
        tick();
        rf_load = 1'b0;

        // Writeback port is live during reset
        wb(1'b1, 4'd4, 32'h44);
        check("rst_rdaddr", 32'(RdAddr), 32'd4);
        check("rst_rddata", RdData, 32'h44);
        tick();
        wb(1'b0, 4'd0, 32'd0);
        check("rdaddr_idle", 32'(RdAddr), 32'd0);
        check("rst_outvalid", 32'(OutValid), 32'd0);
        check("rst_outrs1", OutRs1Data, 32'd0);
        check("rst_outrd", 32'(OutRdAddr), 32'd0);

        // First cycle after release, OutReady low: still ready
        rst_n = 1'b1;
        instr(1'b1, 4'd1, 4'd2, 4'd3);
        check("post_rst_ready", 32'(InReady), 32'd1);
        check("rs1addr_pass", 32'(Rs1Addr), 32'd1);
        tick();
        check("issue1_valid", 32'(OutValid), 32'd1);
        check("issue1_rs1", OutRs1Data, 32'h100);
        check("issue1_rs2", OutRs2Data, 32'h200);
        check("issue1_rd", 32'(OutRdAddr), 32'd3);

        // RAW on x3: stall until writeback, then issue with bypassed data
        OutReady = 1'b1;
        instr(1'b1, 4'd3, 4'd0, 4'd4);
        check("raw_stall0", 32'(InReady), 32'd0);
        tick();
        check("drain_valid", 32'(OutValid), 32'd0);
        check("raw_stall1", 32'(InReady), 32'd0);
        wb(1'b1, 4'd3, 32'hDEADBEEF);
        check("raw_wb_ready", 32'(InReady), 32'd1);
        check("raw_wb_rdaddr", 32'(RdAddr), 32'd3);
        tick();
        check("raw_rs1", OutRs1Data, 32'hDEADBEEF);
        check("raw_rd", 32'(OutRdAddr), 32'd4);
        check("raw_valid", 32'(OutValid), 32'd1);

        // Bypass on non-pending x5, back-to-back issue
        instr(1'b1, 4'd0, 4'd5, 4'd0);
        wb(1'b1, 4'd5, 32'h22);
        check("byp_ready", 32'(InReady), 32'd1);
        tick();
        check("byp_rs2", OutRs2Data, 32'h22);
        check("byp_rs1_x0", OutRs1Data, 32'd0);
        check("byp_valid", 32'(OutValid), 32'd1);
        wb(1'b0, 4'd0, 32'd0);

        // Backpressure: bundle held four cycles, then replaced in one
        instr(1'b1, 4'd3, 4'd5, 4'd6);
        tick();
        check("bp_pre_rs1", OutRs1Data, 32'hDEADBEEF);
        check("bp_pre_rs2", OutRs2Data, 32'h22);
        OutReady = 1'b0;
        instr(1'b1, 4'd1, 4'd2, 4'd8);
        for (int i = 0; i < 4; i++) begin
            check("bp_ready", 32'(InReady), 32'd0);
            tick();
            check("bp_valid", 32'(OutValid), 32'd1);
            check("bp_rs1", OutRs1Data, 32'hDEADBEEF);
            check("bp_rs2", OutRs2Data, 32'h22);
            check("bp_rd", 32'(OutRdAddr), 32'd6);
        end
        OutReady = 1'b1;
        #1;
        check("bp_release_ready", 32'(InReady), 32'd1);
        tick();
        check("bp_new_valid", 32'(OutValid), 32'd1);
        check("bp_new_rs1", OutRs1Data, 32'h100);
        check("bp_new_rs2", OutRs2Data, 32'h200);
        check("bp_new_rd", 32'(OutRdAddr), 32'd8);

        // Retire x4, x6, x8 while the stage drains
        instr(1'b0, 4'd0, 4'd0, 4'd0);
        wb(1'b1, 4'd4, 32'h4444);
        tick();
        check("drain2_valid", 32'(OutValid), 32'd0);
        wb(1'b1, 4'd6, 32'h6666);
        tick();
        wb(1'b1, 4'd8, 32'h8888);
        tick();
        wb(1'b0, 4'd0, 32'd0);
        instr(1'b1, 4'd4, 4'd6, 4'd8);
        check("cleared_ready", 32'(InReady), 32'd1);
        tick();
        check("cleared_rs1", OutRs1Data, 32'h4444);
        check("cleared_rs2", OutRs2Data, 32'h6666);

        // x0 never stalls and writeback to x0 is dropped
        instr(1'b1, 4'd0, 4'd0, 4'd0);
        wb(1'b1, 4'd0, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            check("x0_ready", 32'(InReady), 32'd1);
            check("x0_rdaddr", 32'(RdAddr), 32'd0);
            tick();
            check("x0_rs1", OutRs1Data, 32'd0);
            check("x0_valid", 32'(OutValid), 32'd1);
        end
        wb(1'b0, 4'd0, 32'd0);

        // WAW race on x7: set wins over same-cycle clear
        instr(1'b1, 4'd0, 4'd0, 4'd7);
        tick();
        check("waw_dest_hz", 32'(InReady), 32'd0);
        wb(1'b1, 4'd7, 32'h77);
        check("waw_ready", 32'(InReady), 32'd1);
        tick();
        check("waw_rd", 32'(OutRdAddr), 32'd7);
        wb(1'b0, 4'd0, 32'd0);
        instr(1'b1, 4'd7, 4'd0, 4'd0);
        check("waw_still_pending", 32'(InReady), 32'd0);
        tick();
        check("waw_drain", 32'(OutValid), 32'd0);

        // Reset during a stall on x2 wipes the scoreboard
        instr(1'b1, 4'd0, 4'd0, 4'd2);
        check("x2_set_ready", 32'(InReady), 32'd1);
        tick();
        instr(1'b1, 4'd2, 4'd0, 4'd0);
        check("x2_stall", 32'(InReady), 32'd0);
        tick();
        check("x2_stall_valid", 32'(OutValid), 32'd0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(OutValid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", 32'(InReady), 32'd1);
        tick();
        check("mid_rst_issue_valid", 32'(OutValid), 32'd1);
        check("mid_rst_issue_rs1", OutRs1Data, 32'h200);
        instr(1'b1, 4'd7, 4'd0, 4'd0);
        check("x7_cleared", 32'(InReady), 32'd1);
        instr(1'b0, 4'd0, 4'd0, 4'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
